// File: rtl/adc_pkg.sv
// Shared constants, header layout and state encoding
// for the ADC frame packer.
package adc_pkg;

    localparam logic [15:0] ADC_MAGIC = 16'hDA15;
    localparam int MAX_CH = 8;

    localparam int HDR_MASK_LSB = 0;
    localparam int HDR_SEQ_LSB = 8;
    localparam int HDR_MAGIC_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_TS,
        ST_DATA
    } state_e;

    function automatic logic [31:0] hdr_word(
        input logic [15:0] magic,
        input logic [7:0] s,
        input logic [7:0] m
    );
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 16] = magic;
        h[HDR_SEQ_LSB +: 8] = s;
        h[HDR_MASK_LSB +: 8] = m;
        return h;
    endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// FIFO write port between the frame packer and the
// downstream FIFO.
interface adc_frame_packer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fifo_data;
    logic fifo_wr_en;
    logic fifo_full;

    modport master (
        output fifo_data,
        output fifo_wr_en,
        input fifo_full
    );

    modport slave (
        input fifo_data,
        input fifo_wr_en,
        output fifo_full
    );
endinterface

// File: rtl/frame_channel_scan.sv
// Lowest-set-bit encoder over the channels still to emit,
// with a flag marking the final remaining channel.
module frame_channel_scan
    import adc_pkg::*;
#(
    parameter int N = MAX_CH,
    parameter int IW = 3
) (
    input logic [N-1:0] vec,
    output logic [IW-1:0] idx,
    output logic any,
    output logic last
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
        last = any && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Collects ADC channel strobes and writes each acquisition
// to the FIFO as a header/timestamp/sample burst.
module adc_frame_packer
    import adc_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int TS_W = 32,
    parameter int TIMEOUT = 4096,
    parameter logic [15:0] MAGIC = ADC_MAGIC
) (
    input logic clock_84_0000,
    input logic reset,
    input logic [NUM_CH*DATA_W-1:0] ch_data,
    input logic [NUM_CH-1:0] ch_ready,
    input logic [NUM_CH-1:0] ch_enable,
    input logic clear_status,
    adc_frame_packer_if.master fifo,
    output logic frame_done,
    output logic busy,
    output logic overrun,
    output logic overflow,
    output logic [7:0] frames_dropped,
    output logic [7:0] seq
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    state_e state, state_nx;

    logic [TS_W-1:0] ts_cnt, ts_latch, ts_frame;
    logic [TMR_W-1:0] timer;
    logic [NUM_CH-1:0] pending, pend_base, cap;
    logic [NUM_CH-1:0] mask, frame_mask;
    logic [NUM_CH-1:0] done, done_nx;
    logic [DATA_W-1:0] slot [NUM_CH];
    logic [DATA_W-1:0] bank [NUM_CH];
    logic [DATA_W-1:0] data_q, data_nx;
    logic last_word, last_nx;
    logic complete, timed_out, trigger, drop, start;
    logic wr, load, end_frame, ovr_set;
    logic [IW-1:0] scan_idx;
    logic scan_any, scan_last;
    logic [7:0] drop_base;

    assign cap = ch_ready & ch_enable;
    assign frame_mask = pending & ch_enable;
    assign complete = (ch_enable != '0)
                   && (frame_mask == ch_enable);
    assign timed_out = (pending != '0) && (timer == TMR_MAX);
    assign trigger = (state == ST_IDLE)
                  && (complete || timed_out);
    assign drop = trigger && fifo.fifo_full;
    assign start = trigger && !fifo.fifo_full;
    // A trigger edge empties the pending set before new strobes land.
    assign pend_base = trigger ? '0 : pending;
    assign ovr_set = (cap & pend_base) != '0;

    assign busy = (state != ST_IDLE);
    assign wr = busy && !fifo.fifo_full;
    assign fifo.fifo_wr_en = wr;
    assign fifo.fifo_data = data_q;

    frame_channel_scan #(
        .N(NUM_CH),
        .IW(IW)
    ) u_scan (
        .vec(mask & ~done),
        .idx(scan_idx),
        .any(scan_any),
        .last(scan_last)
    );

    always_comb begin
        state_nx = state;
        data_nx = data_q;
        load = 1'b0;
        end_frame = 1'b0;
        done_nx = done;
        last_nx = last_word;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_HDR;
                    load = 1'b1;
                    data_nx = DATA_W'(hdr_word(
                        MAGIC, seq, 8'(frame_mask)));
                end
            end
            ST_HDR: begin
                if (wr) begin
                    state_nx = ST_TS;
                    load = 1'b1;
                    data_nx = DATA_W'(ts_frame);
                end
            end
            ST_TS, ST_DATA: begin
                if (wr) begin
                    if ((state == ST_TS && !scan_any)
                        || (state == ST_DATA && last_word)) begin
                        state_nx = ST_IDLE;
                        end_frame = 1'b1;
                    end else begin
                        state_nx = ST_DATA;
                        load = 1'b1;
                        data_nx = bank[scan_idx];
                        done_nx = done
                                | (NUM_CH'(1) << scan_idx);
                        last_nx = scan_last;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_84_0000 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            data_q <= '0;
            done <= '0;
            last_word <= 1'b0;
            mask <= '0;
            ts_frame <= '0;
            seq <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else begin
            state <= state_nx;
            frame_done <= end_frame;
            if (load) data_q <= data_nx;
            done <= trigger ? '0 : done_nx;
            last_word <= trigger ? 1'b0 : last_nx;
            if (trigger) begin
                mask <= frame_mask;
                ts_frame <= ts_latch;
                for (int i = 0; i < NUM_CH; i++)
                    bank[i] <= slot[i];
            end
            if (drop || end_frame) seq <= seq + 8'd1;
        end
    end

    always_ff @(posedge clock_84_0000 or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_latch <= '0;
            timer <= '0;
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) slot[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            pending <= pend_base | cap;
            // Timer saturates so a timeout seen while busy still fires.
            if (pend_base == '0) begin
                if (cap != '0) begin
                    ts_latch <= ts_cnt;
                    timer <= '0;
                end
            end else if (timer != TMR_MAX) begin
                timer <= timer + TMR_W'(1);
            end
            for (int i = 0; i < NUM_CH; i++)
                if (cap[i])
                    slot[i] <= ch_data[i*DATA_W +: DATA_W];
        end
    end

    assign drop_base = clear_status ? 8'd0 : frames_dropped;

    always_ff @(posedge clock_84_0000 or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            overflow <= 1'b0;
            frames_dropped <= '0;
        end else begin
            overrun <= ovr_set || (overrun && !clear_status);
            overflow <= drop || (overflow && !clear_status);
            if (drop && drop_base != 8'hFF)
                frames_dropped <= drop_base + 8'd1;
            else
                frames_dropped <= drop_base;
        end
    end

endmodule
